// File: rtl/program_rom_arbiter.sv
// Round-robin arbiter sharing one combinational ROM read port between a
// multi-byte instruction-fetch burst requester and a single-byte data requester.
module program_rom_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_req,
  input  logic [ADDR_W-1:0]           fetch_addr,
  output logic                        fetch_ack,
  output logic [DATA_W*BURST_LEN-1:0] fetch_data,
  input  logic                        data_req,
  input  logic [ADDR_W-1:0]           data_addr,
  output logic                        data_ack,
  output logic [DATA_W-1:0]           data_out,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [DATA_W-1:0]           rom_data,
  output logic                        busy
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BURST_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [ADDR_W-1:0]           base_q, base_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        lastData_q, lastData_d;
  logic [DATA_W*BURST_LEN-1:0] fetchData_q, fetchData_d;
  logic [DATA_W-1:0]           dataOut_q, dataOut_d;

  // lastData_q also identifies the port being served while in ACK.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    lastData_d  = lastData_q;
    fetchData_d = fetchData_q;
    dataOut_d   = dataOut_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_req && (!data_req || lastData_q)) begin
          state_d    = S_FETCH;
          base_d     = fetch_addr;
          cnt_d      = '0;
          lastData_d = 1'b0;
        end else if (data_req) begin
          state_d    = S_DATA;
          base_d     = data_addr;
          cnt_d      = '0;
          lastData_d = 1'b1;
        end
      end
      S_FETCH: begin
        for (int k = 0; k < BURST_LEN; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            fetchData_d[k*DATA_W +: DATA_W] = rom_data;
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_LANE) begin
          state_d = S_ACK;
        end
      end
      S_DATA: begin
        dataOut_d = rom_data;
        state_d   = S_ACK;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset leaves lastData set so fetch wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      lastData_q  <= 1'b1;
      fetchData_q <= '0;
      dataOut_q   <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      lastData_q  <= lastData_d;
      fetchData_q <= fetchData_d;
      dataOut_q   <= dataOut_d;
    end
  end

  always_comb begin
    rom_addr = '0;
    if (state_q == S_FETCH) begin
      rom_addr = base_q + ADDR_W'(cnt_q);
    end else if (state_q == S_DATA) begin
      rom_addr = base_q;
    end
  end

  assign fetch_ack  = (state_q == S_ACK) && !lastData_q;
  assign data_ack   = (state_q == S_ACK) && lastData_q;
  assign busy       = (state_q != S_IDLE);
  assign fetch_data = fetchData_q;
  assign data_out   = dataOut_q;

endmodule

// File: tb/tb_program_rom_arbiter.sv
// Bench for program_rom_arbiter: a transaction-timeline model predicts every
// cycle's outputs, and directed scenarios pin that model with literal values.
module tb_program_rom_arbiter;

  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetch_req = 1'b0;
  logic [7:0]    fetch_addr = 8'h00;
  logic          fetch_ack;
  logic [31:0]   fetch_data;
  logic          data_req = 1'b0;
  logic [7:0]    data_addr = 8'h00;
  logic          data_ack;
  logic [7:0]    data_out;
  logic [7:0]    rom_addr;
  logic [7:0]    rom_data;
  logic          busy;

  logic [7:0]    romMem [256];

  typedef struct packed {
    logic        busy;
    logic [7:0]  addr;
    logic        fack;
    logic        dack;
    logic [31:0] fdata;
    logic [7:0]  dout;
  } exp_t;

  exp_t       expQ[$];
  logic       lastData = 1'b1;
  logic [7:0] heldDout = 8'h00;
  int         errors = 0;
  int         checks = 0;

  program_rom_arbiter #(.ADDR_W(8), .DATA_W(8), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .data_req(data_req), .data_addr(data_addr), .data_ack(data_ack), .data_out(data_out),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  assign rom_data = romMem[rom_addr];

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic loadRom(input bit scrambled);
    for (int i = 0; i < 256; i++) romMem[i] = scrambled ? 8'(i * 7 + 3) : 8'(i);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // On each idle cycle the model decides the upcoming grant and lays out the
  // whole transaction as one expected entry per cycle.
  task automatic compareLoop();
    exp_t       cur;
    exp_t       e;
    logic       idleNow;
    logic [31:0] fd;
    logic [7:0] ak;
    forever begin
      @(negedge clk);
      idleNow = 1'b0;
      if (!rst) begin
        expQ.delete();
        lastData = 1'b1;
        heldDout = 8'h00;
        cur = '0;
      end else if (expQ.size() == 0) begin
        cur = '0;
        cur.dout = heldDout;
        idleNow = 1'b1;
      end else begin
        cur = expQ.pop_front();
      end
      if (cur.dack) heldDout = cur.dout;
      checkOutput("model busy", 32'(busy), 32'(cur.busy));
      checkOutput("model rom_addr", 32'(rom_addr), 32'(cur.addr));
      checkOutput("model fetch_ack", 32'(fetch_ack), 32'(cur.fack));
      checkOutput("model data_ack", 32'(data_ack), 32'(cur.dack));
      checkOutput("model data_out", 32'(data_out), 32'(cur.dout));
      if (!rst || cur.fack) checkOutput("model fetch_data", fetch_data, cur.fdata);
      if (idleNow) begin
        if (fetch_req && (!data_req || lastData)) begin
          lastData = 1'b0;
          fd = '0;
          for (int k = 0; k < BL; k++) begin
            ak = fetch_addr + 8'(k);
            fd[k*8 +: 8] = romMem[ak];
            e = '0;
            e.busy = 1'b1;
            e.addr = ak;
            e.dout = heldDout;
            expQ.push_back(e);
          end
          e = '0;
          e.busy = 1'b1;
          e.fack = 1'b1;
          e.fdata = fd;
          e.dout = heldDout;
          expQ.push_back(e);
        end else if (data_req) begin
          lastData = 1'b1;
          e = '0;
          e.busy = 1'b1;
          e.addr = data_addr;
          e.dout = heldDout;
          expQ.push_back(e);
          e = '0;
          e.busy = 1'b1;
          e.dack = 1'b1;
          e.dout = romMem[data_addr];
          expQ.push_back(e);
        end
      end
    end
  endtask

  task automatic runFetch(input logic [7:0] a, input logic [31:0] expData);
    nextCycle();
    fetch_req = 1'b1;
    fetch_addr = a;
    @(posedge clk);
    for (int k = 0; k < BL; k++) begin
      @(negedge clk);
      checkOutput("fetch rom_addr", 32'(rom_addr), 32'(8'(a + 8'(k))));
    end
    @(negedge clk);
    checkOutput("fetch_ack pulse", 32'(fetch_ack), 32'd1);
    checkOutput("fetch_data literal", fetch_data, expData);
    nextCycle();
    fetch_req = 1'b0;
    @(negedge clk);
    checkOutput("fetch_ack one cycle", 32'(fetch_ack), 32'd0);
  endtask

  task automatic runData(input logic [7:0] a, input logic [7:0] newAddr, input logic [7:0] expByte);
    nextCycle();
    data_req = 1'b1;
    data_addr = a;
    @(posedge clk);
    #2;
    data_req = 1'b0;
    data_addr = newAddr;
    @(negedge clk);
    checkOutput("data busy", 32'(busy), 32'd1);
    checkOutput("data rom_addr", 32'(rom_addr), 32'(a));
    @(negedge clk);
    checkOutput("data_ack pulse", 32'(data_ack), 32'd1);
    checkOutput("data_out literal", 32'(data_out), 32'(expByte));
  endtask

  task automatic applyStimulus();
    int   ackCount;
    logic [3:0] order;

    loadRom(1'b0);
    repeat (4) begin
      nextCycle();
      fetch_req = 1'($urandom);
      data_req = 1'($urandom);
      fetch_addr = 8'($urandom);
      data_addr = 8'($urandom);
    end
    @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset fetch_data", fetch_data, 32'd0);
    checkOutput("reset data_out", 32'(data_out), 32'd0);
    nextCycle();
    fetch_req = 1'b0;
    data_req = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post-reset busy", 32'(busy), 32'd0);

    $display("[TB] fetch burst and wrap-around");
    runFetch(8'h10, 32'h13121110);
    runFetch(8'hFE, 32'h0100FFFE);

    $display("[TB] data read with inputs changed after grant");
    loadRom(1'b1);
    runData(8'h42, 8'h99, 8'hD1);

    $display("[TB] contention");
    nextCycle();
    fetch_addr = 8'h20;
    data_addr = 8'h30;
    fetch_req = 1'b1;
    data_req = 1'b1;
    ackCount = 0;
    order = 4'b0000;
    for (int c = 0; c < 30 && ackCount < 4; c++) begin
      @(negedge clk);
      if (fetch_ack || data_ack) begin
        order[ackCount] = data_ack;
        if (fetch_ack) checkOutput("contention fetch_data", fetch_data, 32'hF8F1EAE3);
        else checkOutput("contention data_out", 32'(data_out), 32'h53);
        ackCount++;
      end
    end
    checkOutput("contention ack count", 32'(ackCount), 32'd4);
    checkOutput("contention grant order", 32'(order), 32'b1010);
    nextCycle();
    fetch_req = 1'b0;
    data_req = 1'b0;
    repeat (2) nextCycle();

    $display("[TB] mid-burst reset");
    loadRom(1'b0);
    fetch_req = 1'b1;
    fetch_addr = 8'h50;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("abort fetch_data", fetch_data, 32'd0);
    fetch_req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("abort no ack", 32'(fetch_ack | data_ack), 32'd0);
    end
    nextCycle();
    rst = 1'b1;

    // Reset restores fetch priority for the first contention.
    nextCycle();
    fetch_addr = 8'h20;
    data_addr = 8'h30;
    fetch_req = 1'b1;
    data_req = 1'b1;
    ackCount = 0;
    for (int c = 0; c < 12 && ackCount == 0; c++) begin
      @(negedge clk);
      if (fetch_ack || data_ack) begin
        checkOutput("post-reset first ack is fetch", 32'(fetch_ack), 32'd1);
        checkOutput("post-reset fetch_data", fetch_data, 32'h23222120);
        ackCount++;
      end
    end
    checkOutput("post-reset ack seen", 32'(ackCount), 32'd1);
    nextCycle();
    fetch_req = 1'b0;
    data_req = 1'b0;
    runFetch(8'h10, 32'h13121110);
    repeat (2) nextCycle();
  endtask

  initial begin
    fork
      compareLoop();
    join_none
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
